smaqa_issue_ctrl: RTL and testbench

SMAQA_ISSUE_CTRL -- requirements
Module: smaqa_issue_ctrl

---
 rtl/ariane_pkg.sv | 5 +
 rtl/smaqa_pkg.sv | 12 +
 rtl/smaqa_wdt.sv | 23 ++
 rtl/smaqa_issue_ctrl.sv | 155 +++++++++++++++
 tb/tb_smaqa_issue_ctrl.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/ariane_pkg.sv
// Minimal slice of the core package: only the transaction-id width the
// SMAQA issue controller depends on.
package ariane_pkg;
  localparam int unsigned TRANS_ID_BITS = 3;
endpackage

// File: rtl/smaqa_pkg.sv
// Shared SMAQA types: controller state encoding and watchdog default.
package smaqa_pkg;
  localparam int unsigned WDT_CYCLES_DEF = 64;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_WB    = 3'd4
  } state_e;
endpackage

// File: rtl/smaqa_wdt.sv
// WAIT-state watchdog: counts while i_run is high, restarts from zero each
// time i_run drops, and flags expiry on the CYCLES-th consecutive cycle.
module smaqa_wdt #(
  parameter int unsigned CYCLES = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic i_run,
  output logic o_expired
);
  localparam int unsigned CW = $clog2(CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic [CW-1:0] r_cnt;

  // Count WAIT cycles; hold at the last value so expiry cannot wrap.
  always_ff @(posedge clk_i) begin
    if (rst_i || !i_run) r_cnt <= '0;
    else if (r_cnt != LAST) r_cnt <= r_cnt + 1'b1;
  end

  assign o_expired = i_run && (r_cnt == LAST);
endmodule

// File: rtl/smaqa_issue_ctrl.sv
// SMAQA issue controller: reads rs1/rs2/rd from the regfile, issues one
// multiply-accumulate to the multiplier, waits for the matching result and
// writes it back to rd. One operation in flight at most.
// Optional build macro SMAQA_WDT_EN adds a WAIT-state timeout (err_o).
module smaqa_issue_ctrl
  import smaqa_pkg::*;
#(
  parameter int unsigned TRANS_ID_BITS = ariane_pkg::TRANS_ID_BITS,
  parameter int unsigned WDT_CYCLES    = WDT_CYCLES_DEF
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     instr_valid_i,
  output logic                     instr_ready_o,
  input  logic [4:0]               rs1_i,
  input  logic [4:0]               rs2_i,
  input  logic [4:0]               rd_i,
  output logic [2:0][4:0]          raddr_o,
  input  logic [2:0][31:0]         rdata_i,
  output logic                     mult_valid_o,
  input  logic                     mult_ready_i,
  output logic [31:0]              operand_a_o,
  output logic [31:0]              operand_b_o,
  output logic [31:0]              operand_c_o,
  output logic [TRANS_ID_BITS-1:0] trans_id_o,
  input  logic                     mult_valid_i,
  input  logic [31:0]              mult_result_i,
  input  logic [TRANS_ID_BITS-1:0] mult_trans_id_i,
  output logic [4:0]               waddr_o,
  output logic [31:0]              wdata_o,
  output logic                     we_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o
);
  state_e                   r_state, w_state_nxt;
  logic [4:0]               r_rs1, r_rs2, r_rd;
  logic [31:0]              r_op_a, r_op_b, r_op_c, r_result;
  logic [TRANS_ID_BITS-1:0] r_tid;
  logic                     w_hs_instr, w_res_hit, w_err, w_retire;

  assign w_hs_instr = (r_state == ST_IDLE) && instr_valid_i;
  assign w_res_hit  = (r_state == ST_WAIT) && mult_valid_i && (mult_trans_id_i == r_tid);
  // The id advances only when the outstanding op retires, so WAIT compares
  // against the id that was actually issued.
  assign w_retire   = w_res_hit || w_err;

`ifdef SMAQA_WDT_EN
  logic w_wdt_exp;

  smaqa_wdt #(.CYCLES(WDT_CYCLES)) u_wdt (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .i_run     (r_state == ST_WAIT),
    .o_expired (w_wdt_exp)
  );
`else
  logic w_unused_wdt;
  assign w_unused_wdt = (WDT_CYCLES == 0);
`endif

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state and handshake/strobe decode.
  always_comb begin
    w_state_nxt   = r_state;
    instr_ready_o = 1'b0;
    mult_valid_o  = 1'b0;
    we_o          = 1'b0;
    done_o        = 1'b0;
    w_err         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        instr_ready_o = 1'b1;
        if (instr_valid_i) w_state_nxt = ST_READ;
      end
      ST_READ:  w_state_nxt = ST_ISSUE;
      ST_ISSUE: begin
        mult_valid_o = 1'b1;
        if (mult_ready_i) w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (w_res_hit) w_state_nxt = ST_WB;
`ifdef SMAQA_WDT_EN
        else if (w_wdt_exp) begin
          w_err       = 1'b1;
          w_state_nxt = ST_IDLE;
        end
`endif
      end
      ST_WB: begin
        done_o      = 1'b1;
        we_o        = (r_rd != 5'd0);
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Instruction fields latch only on the IDLE handshake.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rs1 <= '0;
      r_rs2 <= '0;
      r_rd  <= '0;
    end else if (w_hs_instr) begin
      r_rs1 <= rs1_i;
      r_rs2 <= rs2_i;
      r_rd  <= rd_i;
    end
  end

  // Operand capture in READ, result capture on a matching response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_op_c   <= '0;
      r_result <= '0;
    end else begin
      if (r_state == ST_READ) begin
        r_op_a <= rdata_i[0];
        r_op_b <= rdata_i[1];
        r_op_c <= rdata_i[2];
      end
      if (w_res_hit) r_result <= mult_result_i;
    end
  end

  // Transaction id, wraps naturally at 2^TRANS_ID_BITS.
  always_ff @(posedge clk_i) begin
    if (rst_i)         r_tid <= '0;
    else if (w_retire) r_tid <= r_tid + 1'b1;
  end

  // Present addresses combinationally at the handshake so the synchronous
  // regfile returns data during READ; hold the latched ones afterwards.
  always_comb begin
    if (r_state == ST_IDLE) raddr_o = {rd_i, rs2_i, rs1_i};
    else                    raddr_o = {r_rd, r_rs2, r_rs1};
  end

  assign operand_a_o = r_op_a;
  assign operand_b_o = r_op_b;
  assign operand_c_o = r_op_c;
  assign trans_id_o  = r_tid;
  assign waddr_o     = r_rd;
  assign wdata_o     = r_result;
  assign busy_o      = (r_state != ST_IDLE);
  assign err_o       = w_err;
endmodule

// File: tb/tb_smaqa_issue_ctrl.sv
// Bench for smaqa_issue_ctrl: table of SMAQA instructions driven through a
// regfile and multiplier model, writebacks checked against a scoreboard,
// plus hand sequences for reset-in-WAIT and the WAIT timeout behaviour.
module tb_smaqa_issue_ctrl;
  localparam int TIDW = 2;

  logic              clk = 1'b0;
  logic              rst_i = 1'b1;
  logic              instr_valid_i = 1'b0;
  logic              instr_ready_o;
  logic [4:0]        rs1_i = '0, rs2_i = '0, rd_i = '0;
  logic [2:0][4:0]   raddr_o;
  logic [2:0][31:0]  rdata_i = '0;
  logic              mult_valid_o;
  logic              mult_ready_i = 1'b0;
  logic [31:0]       operand_a_o, operand_b_o, operand_c_o;
  logic [TIDW-1:0]   trans_id_o;
  logic              mult_valid_i = 1'b0;
  logic [31:0]       mult_result_i = '0;
  logic [TIDW-1:0]   mult_trans_id_i = '0;
  logic [4:0]        waddr_o;
  logic [31:0]       wdata_o;
  logic              we_o, busy_o, done_o, err_o;

  always #5 clk = ~clk;

  smaqa_issue_ctrl #(.TRANS_ID_BITS(TIDW), .WDT_CYCLES(8)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i),
    .raddr_o(raddr_o), .rdata_i(rdata_i),
    .mult_valid_o(mult_valid_o), .mult_ready_i(mult_ready_i),
    .operand_a_o(operand_a_o), .operand_b_o(operand_b_o), .operand_c_o(operand_c_o),
    .trans_id_o(trans_id_o),
    .mult_valid_i(mult_valid_i), .mult_result_i(mult_result_i), .mult_trans_id_i(mult_trans_id_i),
    .waddr_o(waddr_o), .wdata_o(wdata_o), .we_o(we_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  // Synchronous-read regfile model.
  logic [31:0] rf [32];
  always @(posedge clk)
    for (int k = 0; k < 3; k++) rdata_i[k] <= rf[raddr_o[k]];

  typedef struct {
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] a, b, c;
    int          rdy, res;
    bit          wrong, noise;
    logic [31:0] exp_wdata;
    bit          exp_we;
  } vec_t;

  typedef struct {
    logic [4:0]      waddr;
    logic [31:0]     wdata;
    bit              we;
    logic [TIDW-1:0] id;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Multiplier model: signed quad-byte dot product accumulated onto c.
  function automatic logic [31:0] smaqa(input logic [31:0] a, b, c);
    logic signed [31:0] s;
    s = $signed(c);
    for (int i = 0; i < 4; i++)
      s = s + $signed(a[i*8 +: 8]) * $signed(b[i*8 +: 8]);
    return s;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input logic [TIDW-1:0] exp_id);
    int c, vcnt, wcnt;
    bit issued, hs_pend, done_seen;
    logic [31:0] res;
    exp_t e;
    rf[v.rs1] = v.a;
    rf[v.rs2] = v.b;
    if (v.rd != 0) rf[v.rd] = v.c;
    sbq.push_back('{v.rd, v.exp_wdata, v.exp_we, exp_id});
    @(negedge clk);
    chk("instr_ready_idle", instr_ready_o, 1);
    instr_valid_i = 1'b1; rs1_i = v.rs1; rs2_i = v.rs2; rd_i = v.rd;
    c = 0; vcnt = 0; wcnt = 0; issued = 0; hs_pend = 0; done_seen = 0; res = '0;
    while (!done_seen && c < 100) begin
      @(negedge clk);
      c++;
      if (hs_pend) begin issued = 1; hs_pend = 0; wcnt = 0; end
      else if (issued) wcnt++;
      mult_valid_i = 1'b0;
      if (v.noise) begin
        instr_valid_i = 1'b1; rs1_i = ~v.rs1; rs2_i = ~v.rs2; rd_i = ~v.rd;
      end else instr_valid_i = 1'b0;
      chk("we_only_in_wb", we_o & ~done_o, 0);
      if (busy_o && !done_o) chk("raddr_hold", raddr_o, {v.rd, v.rs2, v.rs1});
      if (mult_valid_o) begin
        vcnt++;
        chk("operand_a", operand_a_o, v.a);
        chk("operand_b", operand_b_o, v.b);
        chk("operand_c", operand_c_o, v.c);
        chk("trans_id", trans_id_o, exp_id);
        res = smaqa(operand_a_o, operand_b_o, operand_c_o);
        mult_ready_i = (vcnt > v.rdy);
        hs_pend = mult_ready_i;
      end else mult_ready_i = 1'b0;
      if (issued && !done_o) begin
        if (v.wrong && wcnt == v.res) begin
          mult_valid_i = 1'b1; mult_trans_id_i = exp_id + 1'b1; mult_result_i = 32'hDEADBEEF;
        end else if (wcnt == v.res + (v.wrong ? 1 : 0)) begin
          mult_valid_i = 1'b1; mult_trans_id_i = exp_id; mult_result_i = res;
        end
      end
      if (done_o) begin
        done_seen = 1;
        instr_valid_i = 1'b0;
        e = sbq.pop_front();
        chk("we", we_o, e.we);
        chk("waddr", waddr_o, e.waddr);
        if (e.we) chk("wdata", wdata_o, e.wdata);
        chk("err_quiet", err_o, 0);
        chk("latency", c, 4 + v.rdy + v.res + (v.wrong ? 1 : 0));
        chk("valid_cycles", vcnt, v.rdy + 1);
      end
    end
    if (!done_seen) chk("done_timeout", 0, 1);
    mult_ready_i = 1'b0;
    mult_valid_i = 1'b0;
    instr_valid_i = 1'b0;
  endtask

  // Issue one instruction and return at the first negedge spent in WAIT.
  task automatic go_to_wait(input logic [4:0] rs1, rs2, rd);
    bit hs, ok;
    hs = 0; ok = 0;
    @(negedge clk);
    instr_valid_i = 1'b1; rs1_i = rs1; rs2_i = rs2; rd_i = rd;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      instr_valid_i = 1'b0;
      if (hs) begin ok = 1; mult_ready_i = 1'b0; end
      else if (mult_valid_o) begin mult_ready_i = 1'b1; hs = 1; end
    end
    chk("reach_wait", ok, 1);
  endtask

  task automatic check_reset_state();
    chk("rst_busy", busy_o, 0);
    chk("rst_strobes", {we_o, done_o, err_o, mult_valid_o}, 0);
    chk("rst_trans_id", trans_id_o, 0);
    chk("rst_operands", {operand_a_o, operand_b_o}, 0);
    chk("rst_operand_c", operand_c_o, 0);
  endtask

  vec_t vecs[5];

  initial begin
    logic [TIDW-1:0] tid;
    for (int i = 0; i < 32; i++) rf[i] = '0;
    vecs[0] = '{5'd1, 5'd2, 5'd3, 32'h01020304, 32'h05060708, 32'h00000009, 0, 0, 0, 0, 32'h0000004F, 1};
    vecs[1] = '{5'd1, 5'd2, 5'd3, 32'hFFFFFFFF, 32'h01010101, 32'h00000000, 0, 0, 0, 0, 32'hFFFFFFFC, 1};
    vecs[2] = '{5'd4, 5'd5, 5'd0, 32'h7F7F7F7F, 32'h02020202, 32'h00000000, 0, 0, 0, 0, 32'h000003F8, 0};
    vecs[3] = '{5'd6, 5'd7, 5'd8, 32'h80808080, 32'h7F7F7F7F, 32'h00001000, 3, 1, 1, 0, 32'hFFFF1200, 1};
    vecs[4] = '{5'd9, 5'd10, 5'd11, 32'h00FF0102, 32'h03040506, 32'h00000100, 0, 2, 0, 1, 32'h0000010D, 1};

    repeat (2) @(negedge clk);
    check_reset_state();
    rst_i = 1'b0;

    // Back-to-back: ids run 0,1,2,3,0 across the table.
    for (int i = 0; i < 5; i++) run_vec(vecs[i], TIDW'(i));

    // Reset mid-WAIT, then late results: nothing may be written.
    go_to_wait(5'd1, 5'd2, 5'd3);
    tid = trans_id_o;
    for (int i = 0; i < 3; i++) begin
      chk("wait_hold", {busy_o, err_o}, 2'b10);
      @(negedge clk);
    end
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    check_reset_state();
    for (int i = 0; i < 4; i++) begin
      mult_valid_i = 1'b1;
      mult_trans_id_i = (i % 2 == 0) ? tid : '0;
      mult_result_i = 32'h12345678;
      @(negedge clk);
      chk("late_no_write", {we_o, done_o, busy_o}, 0);
    end
    mult_valid_i = 1'b0;

`ifdef SMAQA_WDT_EN
    begin
      int k;
      go_to_wait(5'd1, 5'd2, 5'd3);
      k = 1;
      while (!err_o && k < 20) begin
        @(negedge clk);
        k++;
      end
      chk("wdt_err_cycle", k, 8);
      chk("wdt_no_write", {we_o, done_o}, 0);
      @(negedge clk);
      chk("wdt_idle", {busy_o, err_o, instr_ready_o}, 3'b001);
    end
`else
    go_to_wait(5'd1, 5'd2, 5'd3);
    for (int i = 0; i < 20; i++) begin
      chk("wait_unbounded", {busy_o, err_o, we_o}, 3'b100);
      @(negedge clk);
    end
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    check_reset_state();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
